// File: rtl/spmv_job_scheduler.sv
// Job scheduler for an ap_ctrl_chain SpMV kernel: queues descriptors, launches them
// in order, times each run with a watchdog and reports one completion record per job.
module spmv_job_scheduler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [31:0]             job_base,
    input  logic [31:0]             job_rows,
    input  logic [31:0]             job_nnz,
    output logic                    acc_ap_start,
    input  logic                    acc_ap_ready,
    input  logic                    acc_ap_done,
    input  logic                    acc_ap_idle,
    output logic                    acc_ap_continue,
    output logic [31:0]             acc_base,
    output logic [31:0]             acc_rows,
    output logic [31:0]             acc_nnz,
    output logic                    cmpl_valid,
    input  logic                    cmpl_ready,
    output logic [7:0]              cmpl_id,
    output logic [CNT_W-1:0]        cmpl_cycles,
    output logic                    cmpl_timeout,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  queue_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_REPORT,
        S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [31:0]         r_q_base [DEPTH];
    logic [31:0]         r_q_rows [DEPTH];
    logic [31:0]         r_q_nnz  [DEPTH];
    logic [7:0]          r_q_id   [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [7:0]          r_next_id;

    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_cur_id;
    logic                r_skip;
    logic                r_continue;
    logic [31:0]         r_acc_base;
    logic [31:0]         r_acc_rows;
    logic [31:0]         r_acc_nnz;
    logic [7:0]          r_cmpl_id;
    logic [CNT_W-1:0]    r_cmpl_cycles;
    logic                r_cmpl_timeout;

    logic                w_push;
    logic                w_pop;
    logic                w_launch;
    logic                w_skip;
    logic                w_finish;
    logic                w_expire;
    logic                w_accept;
    logic                w_head_zero;
    logic [CNT_W-1:0]    w_cnt_now;
    logic                w_cnt_limit;

    // Full-queue refusal depends on the level alone, so a same-cycle pop never frees a slot early.
    assign job_ready = ap_rst_n && (r_level < LVL_W'(DEPTH)) && (r_state != S_HALT);
    assign w_push    = job_valid && job_ready;

    assign w_head_zero = (r_q_rows[r_rd_ptr] == '0) || (r_q_nnz[r_rd_ptr] == '0);

    // Count of the current LAUNCH/RUN cycle, inclusive, saturating at all-ones.
    assign w_cnt_now   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_cnt_limit = (w_cnt_now >= CNT_W'(TIMEOUT));

    // NOTE: queue storage carries no reset; the level and pointers alone decide what is valid.
    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            r_q_base[r_wr_ptr] <= job_base;
            r_q_rows[r_wr_ptr] <= job_rows;
            r_q_nnz[r_wr_ptr]  <= job_nnz;
            r_q_id[r_wr_ptr]   <= r_next_id;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_next_id <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_next_id <= r_next_id + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_launch    = 1'b0;
        w_skip      = 1'b0;
        w_finish    = 1'b0;
        w_expire    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    if (w_head_zero) begin
                        w_pop       = 1'b1;
                        w_skip      = 1'b1;
                        w_state_nxt = S_REPORT;
                    end else if (acc_ap_idle) begin
                        w_launch    = 1'b1;
                        w_state_nxt = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                w_pop = acc_ap_ready;
                if (acc_ap_ready && acc_ap_done) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_REPORT;
                end else if (w_cnt_limit) begin
                    w_expire    = 1'b1;
                    w_state_nxt = S_REPORT;
                end else if (acc_ap_ready) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (acc_ap_done) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_REPORT;
                end else if (w_cnt_limit) begin
                    w_expire    = 1'b1;
                    w_state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (cmpl_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = r_cmpl_timeout ? S_HALT : S_IDLE;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_cur_id       <= '0;
            r_skip         <= 1'b0;
            r_continue     <= 1'b0;
            r_acc_base     <= '0;
            r_acc_rows     <= '0;
            r_acc_nnz      <= '0;
            r_cmpl_id      <= '0;
            r_cmpl_cycles  <= '0;
            r_cmpl_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_continue <= w_accept && !r_cmpl_timeout && !r_skip;

            if (w_launch) begin
                r_acc_base <= r_q_base[r_rd_ptr];
                r_acc_rows <= r_q_rows[r_rd_ptr];
                r_acc_nnz  <= r_q_nnz[r_rd_ptr];
                r_cur_id   <= r_q_id[r_rd_ptr];
                r_cnt      <= '0;
            end else if ((r_state == S_LAUNCH) || (r_state == S_RUN)) begin
                r_cnt <= w_cnt_now;
            end

            if (w_skip) begin
                r_cmpl_id      <= r_q_id[r_rd_ptr];
                r_cmpl_cycles  <= '0;
                r_cmpl_timeout <= 1'b0;
                r_skip         <= 1'b1;
            end else if (w_finish || w_expire) begin
                r_cmpl_id      <= r_cur_id;
                r_cmpl_cycles  <= w_cnt_now;
                r_cmpl_timeout <= w_expire;
                r_skip         <= 1'b0;
            end
        end
    end

    assign acc_ap_start    = (r_state == S_LAUNCH);
    assign acc_ap_continue = r_continue;
    assign acc_base        = r_acc_base;
    assign acc_rows        = r_acc_rows;
    assign acc_nnz         = r_acc_nnz;
    assign cmpl_valid      = (r_state == S_REPORT);
    assign cmpl_id         = r_cmpl_id;
    assign cmpl_cycles     = r_cmpl_cycles;
    assign cmpl_timeout    = r_cmpl_timeout;
    assign busy            = (r_state != S_IDLE) || (r_level != '0);
    assign queue_level     = r_level;

endmodule

// File: doc/spmv_job_scheduler.md
SPMV_JOB_SCHEDULER -- requirements
Module: spmv_job_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, job queue entries; power of two, 2..16.
REQ-002 Parameter CNT_W, default 32, cycle counter width.
REQ-003 Parameter TIMEOUT, default 1000000, watchdog limit in cycles per job.
REQ-004 ap_clk  in  1  single clock; all logic on rising edge.
REQ-005 ap_rst_n  in  1  reset, synchronous, active-low.
REQ-006 job_valid  in  1  job descriptor offered.
REQ-007 job_ready  out  1  queue can accept a descriptor.
REQ-008 job_base / job_rows / job_nnz  in  32 each  matrix base address, row count, nonzero count.
REQ-009 acc_ap_start  out  1  SpMV kernel start.
REQ-010 acc_ap_ready / acc_ap_done / acc_ap_idle  in  1 each  kernel handshake.
REQ-011 acc_ap_continue  out  1  kernel continue.
REQ-012 acc_base / acc_rows / acc_nnz  out  32 each  kernel arguments.
REQ-013 cmpl_valid  out  1; cmpl_ready  in  1  completion handshake.
REQ-014 cmpl_id  out  8; cmpl_cycles  out  CNT_W; cmpl_timeout  out  1  completion record.
REQ-015 busy  out  1  FSM not in IDLE or queue non-empty.
REQ-016 queue_level  out  clog2(DEPTH)+1  entries held.

Function
REQ-017 Queue push SHALL occur on job_valid & job_ready; job_ready = (queue_level < DEPTH); a push is refused when full even if a pop occurs the same cycle.
REQ-018 Each pushed job SHALL receive an 8-bit ID from a counter starting at 0, incrementing per push, wrapping 255 -> 0.
REQ-019 FSM states SHALL be IDLE, LAUNCH, RUN, REPORT, HALT.
REQ-020 IDLE -> LAUNCH when queue non-empty, head rows != 0 and nnz != 0, and acc_ap_idle = 1; acc_* arguments SHALL be registered from the head entry on that transition and held stable until the next launch.
REQ-021 Head job with rows = 0 or nnz = 0 SHALL be popped in IDLE without launching, going to REPORT with cmpl_cycles = 0, cmpl_timeout = 0.
REQ-022 LAUNCH: acc_ap_start = 1 until the cycle acc_ap_ready = 1 (inclusive); head popped in that cycle; next state RUN, or REPORT if acc_ap_done = 1 in the same cycle.
REQ-023 RUN: acc_ap_start = 0; -> REPORT on acc_ap_done = 1.
REQ-024 Cycle counter SHALL clear on entering LAUNCH and increment every LAUNCH/RUN cycle; cmpl_cycles = count including the done cycle (start and done in same cycle -> 1); counter saturates at all-ones.
REQ-025 If the counter reaches TIMEOUT in LAUNCH or RUN, the FSM SHALL go to REPORT with cmpl_timeout = 1, and after the completion is accepted go to HALT.
REQ-026 REPORT: cmpl_valid = 1 with id/cycles/timeout stable until cmpl_ready = 1; on acceptance acc_ap_continue pulses 1 cycle (not for timeout or skipped jobs), FSM -> IDLE (or HALT).
REQ-027 HALT: acc_ap_start = 0, job_ready = 0, busy = 1; exited only by reset.
REQ-028 acc_ap_continue SHALL be 0 in every cycle except the REQ-026 pulse.

Reset
REQ-029 With ap_rst_n = 0 at a rising edge: FSM = IDLE, queue empty, ID counter = 0, cycle counter = 0; all outputs 0 except job_ready = 1 from the first cycle after reset release.
REQ-030 Reset mid-job SHALL discard queued and in-flight jobs; no completion is issued for them.

Verification
REQ-031 Push one job (base 0x1000, rows 8, nnz 20); kernel model ap_ready at cycle 2, ap_done 10 cycles after start -> cmpl_id 0, cmpl_cycles 10, one ap_continue pulse on accept.
REQ-032 Push 5 jobs back-to-back with DEPTH 4, kernel stalled -> job_ready = 0 at level 4, fifth accepted only after first pop; completions in order, IDs 0..4.
REQ-033 Job rows = 0 -> no acc_ap_start, completion with cycles 0, no ap_continue.
REQ-034 TIMEOUT = 50, kernel never asserts ap_done -> cmpl_timeout = 1, cmpl_cycles 50, then HALT with job_ready = 0 until reset.
REQ-035 Hold cmpl_ready = 0 for 20 cycles in REPORT -> record stable, no next launch; ap_ready and ap_done in same cycle -> direct REPORT, cycles 1.
REQ-036 Assert reset during RUN with 3 queued jobs -> queue_level 0, no completion, IDs restart at 0.
